traffic_light_ctrl: RTL

//  Two-road (main/side) traffic light controller with a pedestrian walk phase.
//  An internal 3-bit phase down-counter, advanced by a Tick timebase enable,

---
 rtl/traffic_light_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-road (main/side) traffic light controller with a pedestrian walk
//   phase. A 3-bit phase down-counter, advanced only on Tick, times each
//   phase. Main road rests on green until a side or pedestrian request is
//   pending. All lamp outputs are registered and change with State.
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous, active-low reset
//   Tick       in   timebase enable for the phase counter
//   SideReq    in   side-road vehicle sensor (level)
//   PedReq     in   pedestrian button (level)
//   MainLight  out  {R,Y,G} main road, one-hot
//   SideLight  out  {R,Y,G} side road, one-hot
//   PedWalk    out  walk lamp, lit through a pedestrian-serving side green
//   PedAck     out  one-cycle pulse on the first cycle of that side green
//   State      out  current state code (debug)
module traffic_light_ctrl #(
  parameter int MAIN_MIN  = 5,
  parameter int YEL_TIME  = 2,
  parameter int RED_TIME  = 1,
  parameter int SIDE_TIME = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       SideReq,
  input  logic       PedReq,
  output logic [2:0] MainLight,
  output logic [2:0] SideLight,
  output logic       PedWalk,
  output logic       PedAck,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    RED_A    = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    RED_B    = 3'd5
  } state_e;

  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  state_e     state_q, state_d;
  logic [2:0] phase_cnt_q, phase_cnt_d;
  logic       side_pend_q, side_pend_d;
  logic       ped_pend_q, ped_pend_d;
  logic [2:0] main_light_q, main_light_d;
  logic [2:0] side_light_q, side_light_d;
  logic       ped_walk_q, ped_walk_d;
  logic       ped_ack_q, ped_ack_d;
  logic       req;
  logic       phase_done;

  // Counter reload value for a state: duration minus one (DUR=8 loads 7).
  function automatic logic [2:0] dur_m1(input state_e s);
    case (s)
      MAIN_YEL, SIDE_YEL: dur_m1 = 3'(YEL_TIME - 1);
      RED_A, RED_B:       dur_m1 = 3'(RED_TIME - 1);
      SIDE_GRN:           dur_m1 = 3'(SIDE_TIME - 1);
      default:            dur_m1 = 3'(MAIN_MIN - 1);
    endcase
  endfunction

  // Lamp pattern {main, side} for a state.
  function automatic logic [5:0] lamps(input state_e s);
    case (s)
      MAIN_YEL: lamps = {LT_Y, LT_R};
      RED_A,
      RED_B:    lamps = {LT_R, LT_R};
      SIDE_GRN: lamps = {LT_R, LT_G};
      SIDE_YEL: lamps = {LT_R, LT_Y};
      default:  lamps = {LT_G, LT_R};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    side_pend_d = side_pend_q;
    ped_pend_d  = ped_pend_q;
    ped_ack_d   = 1'b0;
    phase_done  = 1'b0;
    req         = side_pend_q | ped_pend_q | SideReq | PedReq;

    // Requests arriving during side green are already being served.
    if (state_q != SIDE_GRN) begin
      if (SideReq) side_pend_d = 1'b1;
      if (PedReq)  ped_pend_d  = 1'b1;
    end

    if (Tick) begin
      if (phase_cnt_q != 3'd0) phase_cnt_d = phase_cnt_q - 3'd1;
      else                     phase_done  = 1'b1;
    end

    case (state_q)
      MAIN_GRN: if (phase_done && req) state_d = MAIN_YEL;
      MAIN_YEL: if (phase_done) state_d = RED_A;
      RED_A:    if (phase_done) state_d = SIDE_GRN;
      SIDE_GRN: if (phase_done) state_d = SIDE_YEL;
      SIDE_YEL: if (phase_done) state_d = RED_B;
      RED_B:    if (phase_done) state_d = MAIN_GRN;
      default:  state_d = MAIN_GRN;  // unreachable codes recover at once
    endcase

    // Any state change reloads the counter for the new phase; while resting
    // in main green with nothing pending the counter simply holds at zero.
    if (state_d != state_q) phase_cnt_d = dur_m1(state_d);

    // Walk decision is made once on side-green entry and held through it.
    ped_walk_d = ped_walk_q;
    if (state_d != SIDE_GRN) begin
      ped_walk_d = 1'b0;
    end else if (state_q != SIDE_GRN) begin
      ped_walk_d  = ped_pend_q | PedReq;
      ped_ack_d   = ped_pend_q | PedReq;
      side_pend_d = 1'b0;  // clear beats a same-edge set
      ped_pend_d  = 1'b0;
    end

    {main_light_d, side_light_d} = lamps(state_d);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= MAIN_GRN;
      phase_cnt_q  <= 3'(MAIN_MIN - 1);
      side_pend_q  <= 1'b0;
      ped_pend_q   <= 1'b0;
      main_light_q <= LT_G;
      side_light_q <= LT_R;
      ped_walk_q   <= 1'b0;
      ped_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      side_pend_q  <= side_pend_d;
      ped_pend_q   <= ped_pend_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      ped_walk_q   <= ped_walk_d;
      ped_ack_q    <= ped_ack_d;
    end
  end

  assign MainLight = main_light_q;
  assign SideLight = side_light_q;
  assign PedWalk   = ped_walk_q;
  assign PedAck    = ped_ack_q;
  assign State     = state_q;

endmodule
